change_dispenser: RTL

- Downstream of the vending controller: consumes its 7-bit `balance` (cents) and a vend/refund request from the user keys.
- Checks funds against an item price and emits a one-cycle vend pulse.
- Pays out change as a sequence of coins (greedy: quarter, dime, nickel), one coin per acknowledge handshake with the coin-release hardware (LED/actuator model).
- Pulses `clear_bal` so the controller zeroes its balance.

---
 rtl/change_pkg.sv | 22 ++
 rtl/change_dispenser_if.sv | 26 ++
 rtl/coin_pick.sv | 32 +++
 rtl/change_dispenser.sv | 119 +++++++++++
 4 files changed

// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM state encoding,
// coin values in cents and the one-hot coin selector codes.
package change_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_VEND     = 3'd1,
    S_CHANGE   = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  localparam logic [6:0] QUARTER = 7'd25;
  localparam logic [6:0] DIME    = 7'd10;
  localparam logic [6:0] NICKEL  = 7'd5;

  localparam logic [2:0] SEL_NONE    = 3'b000;
  localparam logic [2:0] SEL_QUARTER = 3'b100;
  localparam logic [2:0] SEL_DIME    = 3'b010;
  localparam logic [2:0] SEL_NICKEL  = 3'b001;

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle between the vending controller / coin-release hardware (master)
// and the change dispenser (slave).
interface change_dispenser_if;
  logic [6:0] balance;
  logic       vend_req;
  logic       refund_req;
  logic       coin_ack;
  logic       vend;
  logic       deny;
  logic       coin_valid;
  logic [2:0] coin_sel;
  logic       clear_bal;
  logic       busy;
  logic [2:0] residue;
  logic       sold_out;

  modport master (
    output balance, vend_req, refund_req, coin_ack,
    input  vend, deny, coin_valid, coin_sel, clear_bal, busy, residue, sold_out
  );

  modport slave (
    input  balance, vend_req, refund_req, coin_ack,
    output vend, deny, coin_valid, coin_sel, clear_bal, busy, residue, sold_out
  );
endinterface

// File: rtl/coin_pick.sv
// Greedy coin selector: largest coin not exceeding the outstanding change,
// or a none flag when less than a nickel remains.
module coin_pick
  import change_pkg::*;
(
  input  logic [6:0] amount_i,
  output logic [2:0] sel_o,
  output logic [6:0] value_o,
  output logic       none_o
);

  // Pick the largest coin that fits into the remaining amount.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    sel_o   = SEL_NONE;
    value_o = 7'd0;
    none_o  = 1'b0;
    if (amount_i >= QUARTER) begin
      sel_o   = SEL_QUARTER;
      value_o = QUARTER;
    end else if (amount_i >= DIME) begin
      sel_o   = SEL_DIME;
      value_o = DIME;
    end else if (amount_i >= NICKEL) begin
      sel_o   = SEL_NICKEL;
      value_o = NICKEL;
    end else begin
      none_o  = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: checks credit against PRICE, pulses vend, pays change
// one coin per acknowledge (quarter/dime/nickel greedy), then pulses clear_bal.
// Optional macro INVENTORY_EN adds a stock counter loaded from STOCK that
// blocks vending once it reaches zero.
module change_dispenser
  import change_pkg::*;
#(
  parameter logic [6:0] PRICE = 7'd75,
  parameter logic [3:0] STOCK = 4'd8
) (
  input  logic clock,
  input  logic resetn,
  change_dispenser_if.slave bus
);

  state_e     state_q, state_d;
  logic [6:0] change_q, change_d;
  logic       deny_q, deny_d;
  logic [2:0] residue_q, residue_d;

  logic [2:0] pick_sel;
  logic [6:0] pick_value;
  logic       pick_none;
  logic       sold_out;

  coin_pick u_coin_pick (
    .amount_i (change_q),
    .sel_o    (pick_sel),
    .value_o  (pick_value),
    .none_o   (pick_none)
  );

`ifdef INVENTORY_EN
  logic [3:0] stock_q;

  // One item leaves stock on each VEND cycle; VEND is only entered with stock > 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stock_q <= STOCK;
    end else if (state_q == S_VEND) begin
      stock_q <= stock_q - 4'd1;
    end
  end

  assign sold_out = (stock_q == 4'd0);
`else
  // Without the counter stock never limits vending; STOCK has no effect.
  assign sold_out = 1'b0 && (STOCK == 4'd0);
`endif

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      change_q  <= 7'd0;
      deny_q    <= 1'b0;
      residue_q <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      change_q  <= change_d;
      deny_q    <= deny_d;
      residue_q <= residue_d;
    end
  end

  // Next-state and datapath updates; balance is only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    change_d  = change_q;
    deny_d    = 1'b0;
    residue_d = residue_q;
    case (state_q)
      S_IDLE: begin
        if (bus.vend_req) begin
          if (bus.balance >= PRICE && !sold_out) begin
            change_d = bus.balance - PRICE;
            state_d  = S_VEND;
          end else begin
            deny_d   = 1'b1;
          end
        end else if (bus.refund_req) begin
          change_d = bus.balance;
          state_d  = S_CHANGE;
        end
      end
      S_VEND: state_d = S_CHANGE;
      S_CHANGE: begin
        if (pick_none) begin
          residue_d = change_q[2:0];
          state_d   = S_DONE;
        end else begin
          state_d   = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // change_q is frozen here, so the selector still shows the presented coin.
        if (bus.coin_ack) begin
          change_d = change_q - pick_value;
          state_d  = S_CHANGE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state registers.
  assign bus.vend       = (state_q == S_VEND);
  assign bus.coin_valid = (state_q == S_WAIT_ACK);
  assign bus.coin_sel   = (state_q == S_WAIT_ACK) ? pick_sel : SEL_NONE;
  assign bus.clear_bal  = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.deny       = deny_q;
  assign bus.residue    = residue_q;
  assign bus.sold_out   = sold_out;

endmodule
